radix4_booth_seq_mult: RTL and testbench

Parametrised sequential radix-4 Booth multiplier. It is the next generation of the team's sequential/Booth/radix-Booth multipliers. It adds a configurable operand width, a per-transaction signed/unsigned mode, valid/ready handshakes on input and output, and a clock-enable. It processes two multiplier bits per clock and sits between an operand producer and a result consumer in the datapath.

---
 rtl/radix4_booth_seq_mult.sv | 119 +++++++++++
 tb/tb_radix4_booth_seq_mult.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/radix4_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per enabled cycle.
// Signed or unsigned per transaction, valid/ready on both sides.
module radix4_booth_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] OUT
);

  localparam int STEPS = WIDTH / 2 + 1;
  localparam int XW    = WIDTH + 3;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XW-1:0]       a_q, a_d;
  logic [XW-1:0]       acc_q, acc_d;
  logic [XW-1:0]       mplr_q, mplr_d;
  logic [2*WIDTH-1:0]  out_q, out_d;
  logic                ov_q, ov_d;

  logic [XW-1:0]       a_ext, b_ext, pp, sum;
  logic [2*XW-1:0]     shifted;

  assign a_ext = {{3{signed_mode & A[WIDTH-1]}}, A};
  // implicit zero below the multiplier LSB seeds the first Booth window
  assign b_ext = {{2{signed_mode & B[WIDTH-1]}}, B, 1'b0};

  always_comb begin
    pp = '0;
    unique case (mplr_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  assign sum     = acc_q + pp;
  assign shifted = $signed({sum, mplr_q}) >>> 2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    out_d   = out_q;
    ov_d    = ov_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d     = a_ext;
            mplr_d  = b_ext;
            acc_d   = '0;
            cnt_d   = CW'(STEPS);
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d  = shifted[2*XW-1:XW];
          mplr_d = shifted[XW-1:0];
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            // one leftover multiplier bit sits below the product
            out_d   = shifted[2*WIDTH:1];
            ov_d    = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            ov_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & rst;
  assign out_valid = ov_q;
  assign OUT       = out_q;

endmodule

// File: tb/tb_radix4_booth_seq_mult.sv
// Directed bench for radix4_booth_seq_mult at WIDTH=32.
// Hand-computed products, latency, backpressure, enable and reset abort.
module tb_radix4_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        signed_mode = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] OUT;

  int n_chk = 0;
  int n_err = 0;

  radix4_booth_seq_mult #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .OUT         (OUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic sm,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lat,
                     input int gs, input int gl, input bit ack);
    int t;
    bit seen;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk({tag, " ready"}, 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    A           = a;
    B           = b;
    signed_mode = sm;
    tick();
    in_valid    = 1'b0;
    A           = ~a;
    B           = 32'h5a5a_a5a5;
    signed_mode = ~sm;
    chk({tag, " busy"}, 64'(in_ready), 64'd0);
    t    = 0;
    seen = 1'b0;
    while (t < 100 && !seen) begin
      en = !(t >= gs && t < gs + gl);
      tick();
      t++;
      seen = out_valid;
    end
    en = 1'b1;
    chk({tag, " latency"}, 64'(t), 64'(lat));
    chk({tag, " out"}, OUT, exp);
    if (ack) begin
      chk({tag, " no early ready"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
      chk({tag, " ready back"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out", OUT, 64'd0);
    rst = 1'b1;
    tick();
    chk("release ready", 64'(in_ready), 64'd1);

    run("s 12*-32", 1'b1, 32'd12, -32'sd32, -64'sd384, 17, 999, 0, 1'b1);
    run("s -51*-4", 1'b1, -32'sd51, -32'sd4, 64'd204, 17, 999, 0, 1'b1);
    run("s 0*1234", 1'b1, 32'd0, 32'd1234, 64'd0, 17, 999, 0, 1'b1);
    run("u ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'hFFFF_FFFE_0000_0001, 17, 999, 0, 1'b1);
    run("s ones", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'd1, 17, 999, 0, 1'b1);
    run("s minsq", 1'b1, 32'h8000_0000, 32'h8000_0000,
        64'h4000_0000_0000_0000, 17, 999, 0, 1'b1);

    run("s min*max", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF,
        64'hC000_0000_8000_0000, 17, 999, 0, 1'b0);
    in_valid    = 1'b1;
    A           = 32'd3;
    B           = 32'd3;
    signed_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp out", OUT, 64'hC000_0000_8000_0000);
      chk("bp valid", 64'(out_valid), 64'd1);
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp drop", 64'(out_valid), 64'd0);
    chk("bp ready", 64'(in_ready), 64'd1);
    chk("bp out kept", OUT, 64'hC000_0000_8000_0000);

    run("en gap", 1'b1, 32'd13, 32'd20, 64'd260, 22, 3, 5, 1'b1);

    in_valid    = 1'b1;
    A           = 32'd5;
    B           = 32'd7;
    signed_mode = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b0;
    #1;
    chk("abort valid", 64'(out_valid), 64'd0);
    chk("abort out", OUT, 64'd0);
    chk("abort ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("abort release", 64'(in_ready), 64'd1);
    chk("abort no out", 64'(out_valid), 64'd0);

    run("s -12*72", 1'b1, -32'sd12, 32'd72, -64'sd864, 17, 999, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
